// File: rtl/aes_sbox_share_ctrl.sv
// Purpose: shares one LANES-byte S-box between SubBytes (A, 128b) and SubWord (B, 32b); SBOX_SHARE_PRIO_B_EN gives B fixed priority.
// Latency: the accept cycle, then 16/LANES (A) or 4/LANES (B) RUN cycles, then a one-cycle done pulse (done cycle = accept cycle + N + 1).
// Backpressure: ready only in IDLE and only to the arbitration winner; requests are never queued, data sampled on the accept edge.
module aes_sbox_share_ctrl #(
  parameter int LANES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               a_valid,
  output logic               a_ready,
  input  logic [127:0]       a_data,
  output logic               a_done,
  output logic [127:0]       a_result,
  input  logic               b_valid,
  output logic               b_ready,
  input  logic [31:0]        b_data,
  output logic               b_done,
  output logic [31:0]        b_result,
  output logic [8*LANES-1:0] sbox_in,
  input  logic [8*LANES-1:0] sbox_out,
  output logic               busy
);

  localparam int W = 8 * LANES;
  localparam logic [3:0] A_LAST = 4'(16 / LANES - 1);
  localparam logic [3:0] B_LAST = 4'(4 / LANES - 1);

  typedef enum logic [1:0] {IDLE, RUN_A, RUN_B} state_t;

  state_t       state;
  logic [3:0]   cnt;
  logic [127:0] work_buf;
  logic [6:0]   ofs;
  logic         grant_a;
  logic         grant_b;

  // bit offset of the chunk currently in flight; chunk 0 is the least-significant bytes
  assign ofs = 7'(int'(cnt) * W);

`ifndef SBOX_SHARE_PRIO_B_EN
  // 1 = B was granted last; reset to B so that A wins the first contest
  logic last_grant_b;

  // remember who won the most recent accept for round-robin fairness
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant_b <= 1'b1;
    end else if (grant_a) begin
      last_grant_b <= 1'b0;
    end else if (grant_b) begin
      last_grant_b <= 1'b1;
    end
  end
`endif

  // job-level arbitration, only meaningful while idle
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (state == IDLE) begin
`ifdef SBOX_SHARE_PRIO_B_EN
      if (b_valid) begin
        grant_b = 1'b1;
      end else if (a_valid) begin
        grant_a = 1'b1;
      end
`else
      if (a_valid && b_valid) begin
        grant_a = last_grant_b;
        grant_b = !last_grant_b;
      end else begin
        grant_a = a_valid;
        grant_b = b_valid;
      end
`endif
    end
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;
  assign busy    = (state != IDLE);
  assign sbox_in = (state == IDLE) ? '0 : work_buf[ofs +: W];

  // job FSM: latch on accept, stream chunks through the S-box, pulse done on the last chunk
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      work_buf <= '0;
      a_done   <= 1'b0;
      b_done   <= 1'b0;
      a_result <= '0;
      b_result <= '0;
    end else begin
      a_done <= 1'b0;
      b_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_a) begin
            work_buf <= a_data;
            cnt      <= '0;
            state    <= RUN_A;
          end else if (grant_b) begin
            work_buf <= {96'd0, b_data};
            cnt      <= '0;
            state    <= RUN_B;
          end
        end
        RUN_A: begin
          a_result[ofs +: W] <= sbox_out;
          cnt <= cnt + 4'd1;
          if (cnt == A_LAST) begin
            state  <= IDLE;
            a_done <= 1'b1;
          end
        end
        RUN_B: begin
          b_result[ofs[4:0] +: W] <= sbox_out;
          cnt <= cnt + 4'd1;
          if (cnt == B_LAST) begin
            state  <= IDLE;
            b_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_sbox_share_ctrl.sv
// Bench for aes_sbox_share_ctrl: one LANES=4 and one LANES=1 instance, each wired to a behavioural AES S-box.
// Directed vectors with hand-computed results; every check is sampled on the falling clock edge.
// Build with SBOX_SHARE_PRIO_B_EN defined to exercise the fixed-priority arbitration expectations.
module tb_aes_sbox_share_ctrl;

  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  // hand-derived: S-box of 00112233_44556677_8899aabb_ccddeeff, byte by byte
  localparam logic [127:0] PAT     = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] PAT_SUB = 128'h638293c3_1bfc33f5_c4eeacea_4bc12816;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         a_valid4 = 0, a_ready4, a_done4, b_valid4 = 0, b_ready4, b_done4, busy4;
  logic [127:0] a_data4 = '0, a_result4;
  logic [31:0]  b_data4 = '0, b_result4, sbox_in4, sbox_out4;
  logic         a_valid1 = 0, a_ready1, a_done1, b_valid1 = 0, b_ready1, b_done1, busy1;
  logic [127:0] a_data1 = '0, a_result1;
  logic [31:0]  b_data1 = '0, b_result1;
  logic [7:0]   sbox_in1, sbox_out1;

  int n_chk = 0;
  int n_pass = 0;

  always_comb begin
    sbox_out4 = '0;
    for (int i = 0; i < 4; i++) sbox_out4[i*8 +: 8] = SBOX[sbox_in4[i*8 +: 8]];
  end
  assign sbox_out1 = SBOX[sbox_in1];

  aes_sbox_share_ctrl #(.LANES(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid4), .a_ready(a_ready4), .a_data(a_data4), .a_done(a_done4), .a_result(a_result4),
    .b_valid(b_valid4), .b_ready(b_ready4), .b_data(b_data4), .b_done(b_done4), .b_result(b_result4),
    .sbox_in(sbox_in4), .sbox_out(sbox_out4), .busy(busy4)
  );

  aes_sbox_share_ctrl #(.LANES(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid1), .a_ready(a_ready1), .a_data(a_data1), .a_done(a_done1), .a_result(a_result1),
    .b_valid(b_valid1), .b_ready(b_ready1), .b_data(b_data1), .b_done(b_done1), .b_result(b_result1),
    .sbox_in(sbox_in1), .sbox_out(sbox_out1), .busy(busy1)
  );

  task automatic apply_reset();
    rst_n = 1'b0;
    a_valid4 = 0; b_valid4 = 0; a_valid1 = 0; b_valid1 = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++; if ({a_done4, b_done4, busy4} !== 3'b000) $display("FAIL reset_flags4: got %b want 000", {a_done4, b_done4, busy4}); else n_pass++;
    n_chk++; if (a_result4 !== 128'd0) $display("FAIL reset_a_result4: got %h want 0", a_result4); else n_pass++;
    n_chk++; if (b_result4 !== 32'd0) $display("FAIL reset_b_result4: got %h want 0", b_result4); else n_pass++;
    n_chk++; if (sbox_in4 !== 32'd0) $display("FAIL reset_sbox_in4: got %h want 0", sbox_in4); else n_pass++;
    n_chk++; if ({a_done1, b_done1, busy1, sbox_in1} !== 11'd0) $display("FAIL reset_dut1: got %h want 0", {a_done1, b_done1, busy1, sbox_in1}); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++; if ({a_ready4, b_ready4} !== 2'b00) $display("FAIL idle_ready_no_valid: got %b want 00", {a_ready4, b_ready4}); else n_pass++;
  endtask

  task automatic test_b_single();
    b_valid4 = 1; b_data4 = 32'h2f8dff80; #1;
    n_chk++; if ({a_ready4, b_ready4} !== 2'b01) $display("FAIL b_accept_ready: got %b want 01", {a_ready4, b_ready4}); else n_pass++;
    @(negedge clk);
    b_valid4 = 0; b_data4 = 32'hffffffff;
    n_chk++; if (busy4 !== 1'b1) $display("FAIL b_run_busy: got %b want 1", busy4); else n_pass++;
    n_chk++; if (sbox_in4 !== 32'h2f8dff80) $display("FAIL b_run_sbox_in: got %h want 2f8dff80", sbox_in4); else n_pass++;
    n_chk++; if ({b_done4, b_ready4} !== 2'b00) $display("FAIL b_run_done_ready: got %b want 00", {b_done4, b_ready4}); else n_pass++;
    @(negedge clk);
    n_chk++; if (b_done4 !== 1'b1) $display("FAIL b_done_latency: got %b want 1", b_done4); else n_pass++;
    n_chk++; if (b_result4 !== 32'h155d16cd) $display("FAIL b_result: got %h want 155d16cd", b_result4); else n_pass++;
    n_chk++; if ({busy4, sbox_in4} !== 33'd0) $display("FAIL b_done_idle: got %h want 0", {busy4, sbox_in4}); else n_pass++;
    @(negedge clk);
    n_chk++; if (b_done4 !== 1'b0) $display("FAIL b_done_single_pulse: got %b want 0", b_done4); else n_pass++;
    n_chk++; if (b_result4 !== 32'h155d16cd) $display("FAIL b_result_hold: got %h want 155d16cd", b_result4); else n_pass++;
    n_chk++; if (a_done4 !== 1'b0) $display("FAIL b_job_a_done: got %b want 0", a_done4); else n_pass++;
  endtask

  task automatic test_a_job(input logic [127:0] din, input logic [127:0] dexp, input string tag);
    int busy_cnt;
    busy_cnt = 0;
    a_valid4 = 1; a_data4 = din; #1;
    n_chk++; if ({a_ready4, b_ready4} !== 2'b10) $display("FAIL %s_accept_ready: got %b want 10", tag, {a_ready4, b_ready4}); else n_pass++;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      a_valid4 = 0; a_data4 = '1;
      if (busy4) busy_cnt++;
      if (k <= 4) begin
        n_chk++; if (sbox_in4 !== din[(k-1)*32 +: 32]) $display("FAIL %s_chunk%0d: got %h want %h", tag, k-1, sbox_in4, din[(k-1)*32 +: 32]); else n_pass++;
        n_chk++; if (a_done4 !== 1'b0) $display("FAIL %s_early_done%0d: got %b want 0", tag, k, a_done4); else n_pass++;
      end else if (k == 5) begin
        n_chk++; if (a_done4 !== 1'b1) $display("FAIL %s_done_latency: got %b want 1", tag, a_done4); else n_pass++;
        n_chk++; if (a_result4 !== dexp) $display("FAIL %s_result: got %h want %h", tag, a_result4, dexp); else n_pass++;
      end
    end
    n_chk++; if (busy_cnt !== 4) $display("FAIL %s_busy_cycles: got %0d want 4", tag, busy_cnt); else n_pass++;
    n_chk++; if (b_result4 !== 32'h155d16cd) $display("FAIL %s_b_result_untouched: got %h want 155d16cd", tag, b_result4); else n_pass++;
  endtask

  task automatic test_arbitration();
    logic [3:0]   exp_b;
    logic [127:0] exp_a;
    int jobs;
    int seen;
`ifdef SBOX_SHARE_PRIO_B_EN
    exp_b = 4'b1111; exp_a = 128'd0;
`else
    exp_b = 4'b1010; exp_a = {16{8'h63}};
`endif
    apply_reset();
    a_valid4 = 1; b_valid4 = 1; a_data4 = '0; b_data4 = 32'h0000004f;
    jobs = 0;
    for (int cyc = 0; cyc < 80 && jobs < 4; cyc++) begin
      #1;
      if (a_ready4 || b_ready4) begin
        n_chk++; if (b_ready4 !== exp_b[jobs] || a_ready4 !== !exp_b[jobs]) $display("FAIL arb_grant%0d: got a=%b b=%b want b=%b", jobs, a_ready4, b_ready4, exp_b[jobs]); else n_pass++;
        if (jobs > 0) begin
          n_chk++; if ((a_done4 | b_done4) !== 1'b1) $display("FAIL arb_no_bubble%0d: got done=%b want 1", jobs, a_done4 | b_done4); else n_pass++;
        end
        jobs++;
      end
      @(negedge clk);
    end
    a_valid4 = 0; b_valid4 = 0;
    n_chk++; if (jobs !== 4) $display("FAIL arb_jobs_timeout: got %0d want 4", jobs); else n_pass++;
    seen = 0;
    for (int cyc = 0; cyc < 20 && seen == 0; cyc++) begin
      if (b_done4) seen = 1;
      else @(negedge clk);
    end
    n_chk++; if (seen !== 1) $display("FAIL arb_b_done_timeout: got %0d want 1", seen); else n_pass++;
    n_chk++; if (b_result4 !== 32'h63636384) $display("FAIL arb_b_result: got %h want 63636384", b_result4); else n_pass++;
    n_chk++; if (a_result4 !== exp_a) $display("FAIL arb_a_result: got %h want %h", a_result4, exp_a); else n_pass++;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset_midjob();
    int seen;
    a_valid4 = 1; a_data4 = '1;
    @(negedge clk);
    a_valid4 = 0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_chk++; if (a_result4 !== 128'd0) $display("FAIL midrst_a_result: got %h want 0", a_result4); else n_pass++;
    n_chk++; if ({a_done4, busy4, sbox_in4} !== 34'd0) $display("FAIL midrst_idle: got %h want 0", {a_done4, busy4, sbox_in4}); else n_pass++;
    a_valid4 = 1; #1;
    n_chk++; if (a_ready4 !== 1'b1) $display("FAIL midrst_a_ready: got %b want 1", a_ready4); else n_pass++;
    a_valid4 = 0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (a_done4) seen++;
    end
    n_chk++; if (seen !== 0) $display("FAIL midrst_no_done: got %0d pulses want 0", seen); else n_pass++;
  endtask

  task automatic test_lanes1();
    logic [31:0] w;
    w = 32'h0000004f;
    b_valid1 = 1; b_data1 = w; #1;
    n_chk++; if (b_ready1 !== 1'b1) $display("FAIL l1_b_ready: got %b want 1", b_ready1); else n_pass++;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      b_valid1 = 0;
      if (k <= 4) begin
        n_chk++; if (sbox_in1 !== w[(k-1)*8 +: 8]) $display("FAIL l1_b_chunk%0d: got %h want %h", k-1, sbox_in1, w[(k-1)*8 +: 8]); else n_pass++;
        n_chk++; if (b_done1 !== 1'b0) $display("FAIL l1_b_early_done%0d: got %b want 0", k, b_done1); else n_pass++;
      end else begin
        n_chk++; if (b_done1 !== 1'b1) $display("FAIL l1_b_done_latency: got %b want 1", b_done1); else n_pass++;
        n_chk++; if (b_result1 !== 32'h63636384) $display("FAIL l1_b_result: got %h want 63636384", b_result1); else n_pass++;
      end
    end
    a_valid1 = 1; a_data1 = PAT; #1;
    n_chk++; if (a_ready1 !== 1'b1) $display("FAIL l1_a_ready: got %b want 1", a_ready1); else n_pass++;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      a_valid1 = 0;
      if (k <= 16) begin
        n_chk++; if (sbox_in1 !== PAT[(k-1)*8 +: 8] || a_done1 !== 1'b0) $display("FAIL l1_a_chunk%0d: got %h done=%b want %h done=0", k-1, sbox_in1, a_done1, PAT[(k-1)*8 +: 8]); else n_pass++;
      end else begin
        n_chk++; if (a_done1 !== 1'b1) $display("FAIL l1_a_done_latency: got %b want 1", a_done1); else n_pass++;
        n_chk++; if (a_result1 !== PAT_SUB) $display("FAIL l1_a_result: got %h want %h", a_result1, PAT_SUB); else n_pass++;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_b_single();
    test_a_job(128'd0, {16{8'h63}}, "a_zero");
    test_a_job(PAT, PAT_SUB, "a_pat");
    test_arbitration();
    test_reset_midjob();
    test_lanes1();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
